// File: rtl/beehive_vr_pkg.sv
// Shared widths and types for the VR replication blocks.
// Holds message field widths, the vote bitmap width and the START_CHANGE collector state type.
package beehive_vr_pkg;

  localparam int CONFIG_NODE_CNT_W = 4;
  localparam int CONFIG_ADDR_W     = 4;
  localparam int INT_W             = 32;
  localparam int VOTE_MAP_W        = 2 ** CONFIG_ADDR_W;

  typedef enum logic [1:0] {
    SC_IDLE,
    SC_COLLECT,
    SC_QUORUM,
    SC_HIGHER
  } start_change_collect_state_e;

endpackage

// File: rtl/vr_vote_bitmap.sv
// Per-replica seen bitmap with a distinct-vote counter.
// Reused by every quorum collector in the view-change and commit paths.
module vr_vote_bitmap
  import beehive_vr_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         set_en,
  input  logic [CONFIG_ADDR_W-1:0]     idx,
  output logic                         hit,
  output logic [CONFIG_NODE_CNT_W-1:0] cnt
);

  logic [VOTE_MAP_W-1:0] map;

  assign hit = map[idx];

  // NOTE: the map is a handful of flops, so it is reset rather than left for the first
  // clear to initialise; a vote cannot be counted from garbage after power-up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      map <= '0;
      cnt <= '0;
    end else if (clr) begin
      map <= '0;
      cnt <= '0;
    end else if (set_en && !hit) begin
      map[idx] <= 1'b1;
      cnt      <= cnt + CONFIG_NODE_CNT_W'(1);
    end
  end

endmodule

// File: rtl/start_change_collect.sv
// Collects START_CHANGE messages from peers for the view being changed to,
// signalling quorum at f distinct votes or reporting any higher view seen.
module start_change_collect
  import beehive_vr_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [CONFIG_NODE_CNT_W-1:0] cluster_size,
  input  logic [INT_W-1:0]             my_index,
  input  logic                         arm,
  input  logic [INT_W-1:0]             target_view,
  output logic                         arm_rdy,
  input  logic                         msg_val,
  input  logic [INT_W-1:0]             msg_view,
  input  logic [INT_W-1:0]             msg_replica_idx,
  output logic                         msg_rdy,
  output logic                         quorum_val,
  output logic [INT_W-1:0]             quorum_view,
  input  logic                         quorum_rdy,
  output logic                         higher_view_val,
  output logic [INT_W-1:0]             higher_view,
  input  logic                         higher_view_rdy,
  output logic [CONFIG_NODE_CNT_W-1:0] vote_cnt
);

  start_change_collect_state_e state;
  logic [INT_W-1:0]             view_reg;
  logic [CONFIG_NODE_CNT_W-1:0] thresh;
  logic                         idx_ok;
  logic                         reached;
  logic                         map_clr;
  logic                         map_set;
  logic                         map_hit;

  assign thresh      = (cluster_size - CONFIG_NODE_CNT_W'(1)) >> 1;
  assign reached     = (vote_cnt >= thresh);
  assign idx_ok      = (msg_replica_idx != my_index) &&
                       (msg_replica_idx < INT_W'(cluster_size));
  assign quorum_view = view_reg;

  // arm_rdy is only high in IDLE/COLLECT, so an accepted arm always restarts the map.
  assign map_clr = arm && arm_rdy;
  assign map_set = (state == SC_COLLECT) && msg_val && !arm && !reached &&
                   idx_ok && (msg_view == view_reg);

  vr_vote_bitmap u_bitmap (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (map_clr),
    .set_en (map_set),
    .idx    (msg_replica_idx[CONFIG_ADDR_W-1:0]),
    .hit    (map_hit),
    .cnt    (vote_cnt)
  );

  // NOTE: all state here is updated with non-blocking assignments so every branch reads
  // the pre-edge values of state and view_reg, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= SC_IDLE;
      view_reg        <= '0;
      higher_view     <= '0;
      quorum_val      <= 1'b0;
      higher_view_val <= 1'b0;
      msg_rdy         <= 1'b1;
      arm_rdy         <= 1'b1;
    end else begin
      case (state)
        SC_IDLE: begin
          if (arm) begin
            view_reg <= target_view;
            state    <= SC_COLLECT;
          end
        end
        SC_COLLECT: begin
          if (arm) begin
            view_reg <= target_view;
          end else if (reached) begin
            state      <= SC_QUORUM;
            quorum_val <= 1'b1;
            msg_rdy    <= 1'b0;
            arm_rdy    <= 1'b0;
          end else if (msg_val && idx_ok && (msg_view > view_reg)) begin
            higher_view     <= msg_view;
            state           <= SC_HIGHER;
            higher_view_val <= 1'b1;
            msg_rdy         <= 1'b0;
            arm_rdy         <= 1'b0;
          end
        end
        SC_QUORUM: begin
          if (quorum_rdy) begin
            state      <= SC_IDLE;
            quorum_val <= 1'b0;
            msg_rdy    <= 1'b1;
            arm_rdy    <= 1'b1;
          end
        end
        SC_HIGHER: begin
          if (higher_view_rdy) begin
            state           <= SC_IDLE;
            higher_view_val <= 1'b0;
            msg_rdy         <= 1'b1;
            arm_rdy         <= 1'b1;
          end
        end
        default: begin
          state           <= start_change_collect_state_e'('x);
          quorum_val      <= 1'bx;
          higher_view_val <= 1'bx;
          msg_rdy         <= 1'bx;
          arm_rdy         <= 1'bx;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_start_change_collect.sv
// Directed bench for start_change_collect: scoreboard queue of expected quorum /
// higher-view events, popped by a monitor on each output handshake.
module tb_start_change_collect;
  import beehive_vr_pkg::*;

  logic                         clk = 1'b0;
  logic                         rst_n;
  logic [CONFIG_NODE_CNT_W-1:0] cluster_size;
  logic [INT_W-1:0]             my_index;
  logic                         arm;
  logic [INT_W-1:0]             target_view;
  logic                         arm_rdy;
  logic                         msg_val;
  logic [INT_W-1:0]             msg_view;
  logic [INT_W-1:0]             msg_replica_idx;
  logic                         msg_rdy;
  logic                         quorum_val;
  logic [INT_W-1:0]             quorum_view;
  logic                         quorum_rdy;
  logic                         higher_view_val;
  logic [INT_W-1:0]             higher_view;
  logic                         higher_view_rdy;
  logic [CONFIG_NODE_CNT_W-1:0] vote_cnt;

  typedef struct {
    logic             is_quorum;
    logic [INT_W-1:0] view;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   errors  = 0;

  always #5 clk = ~clk;

  start_change_collect dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cluster_size    (cluster_size),
    .my_index        (my_index),
    .arm             (arm),
    .target_view     (target_view),
    .arm_rdy         (arm_rdy),
    .msg_val         (msg_val),
    .msg_view        (msg_view),
    .msg_replica_idx (msg_replica_idx),
    .msg_rdy         (msg_rdy),
    .quorum_val      (quorum_val),
    .quorum_view     (quorum_view),
    .quorum_rdy      (quorum_rdy),
    .higher_view_val (higher_view_val),
    .higher_view     (higher_view),
    .higher_view_rdy (higher_view_rdy),
    .vote_cnt        (vote_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expected event per output handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && quorum_val === 1'b1 && quorum_rdy === 1'b1) begin
        if (exp_q.size() == 0) begin
          vectors++; errors++;
          $display("FAIL sb_unexpected_quorum: got view 0x%0h, expected no event", quorum_view);
        end else begin
          e = exp_q.pop_front();
          check("sb_quorum", {31'd0, 1'b1, quorum_view}, {31'd0, e.is_quorum, e.view});
        end
      end
      if (rst_n === 1'b1 && higher_view_val === 1'b1 && higher_view_rdy === 1'b1) begin
        if (exp_q.size() == 0) begin
          vectors++; errors++;
          $display("FAIL sb_unexpected_higher: got view 0x%0h, expected no event", higher_view);
        end else begin
          e = exp_q.pop_front();
          check("sb_higher", {31'd0, 1'b0, higher_view}, {31'd0, e.is_quorum, e.view});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [CONFIG_NODE_CNT_W-1:0] n);
    rst_n = 1'b0;
    cluster_size = n;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic arm_view(input logic [INT_W-1:0] v);
    arm = 1'b1;
    target_view = v;
    tick();
    arm = 1'b0;
  endtask

  task automatic send(input int idx, input logic [INT_W-1:0] v);
    msg_val = 1'b1;
    msg_replica_idx = INT_W'(idx);
    msg_view = v;
    tick();
    msg_val = 1'b0;
  endtask

  task automatic push(input logic q, input logic [INT_W-1:0] v);
    exp_t e;
    e.is_quorum = q;
    e.view = v;
    exp_q.push_back(e);
  endtask

  task automatic ack_quorum();
    quorum_rdy = 1'b1;
    tick();
    quorum_rdy = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    cluster_size = 4'd5;
    my_index = '0;
    arm = 1'b0;
    target_view = '0;
    msg_val = 1'b0;
    msg_view = '0;
    msg_replica_idx = '0;
    quorum_rdy = 1'b0;
    higher_view_rdy = 1'b0;
    #12;
    check("rst_vote_cnt", vote_cnt, 0);
    check("rst_outputs", {quorum_val, higher_view_val, msg_rdy, arm_rdy}, 4'b0011);
    check("rst_views", {quorum_view, higher_view}, 64'd0);
    rst_n = 1'b1;
    tick();

    // Basic quorum: n=5 -> thresh 2
    arm_view(32'd7);
    push(1'b1, 32'd7);
    send(1, 32'd7); check("basic_cnt_r1", vote_cnt, 1);
    send(1, 32'd7); check("basic_cnt_dup", vote_cnt, 1);
    send(2, 32'd7); check("basic_cnt_r2", vote_cnt, 2);
    check("basic_no_quorum_yet", quorum_val, 0);
    tick();
    check("basic_quorum_val", quorum_val, 1);
    check("basic_quorum_view", quorum_view, 7);
    for (int i = 0; i < 10; i++) begin
      msg_val = 1'b1; msg_replica_idx = 32'd3; msg_view = 32'd7;
      check("hold_quorum", {quorum_val, msg_rdy, arm_rdy, quorum_view}, {3'b100, 32'd7});
      tick();
    end
    msg_val = 1'b0;
    check("hold_vote_cnt", vote_cnt, 2);
    ack_quorum();
    check("basic_after_ack", {quorum_val, msg_rdy, arm_rdy}, 3'b011);

    // Drops: self, out-of-range, lower view
    do_reset(4'd5);
    arm_view(32'd7);
    check("drop_rdy_self", msg_rdy, 1);
    send(0, 32'd7); check("drop_self", vote_cnt, 0);
    check("drop_rdy_range", msg_rdy, 1);
    send(6, 32'd7); check("drop_range", vote_cnt, 0);
    check("drop_rdy_low", msg_rdy, 1);
    send(3, 32'd6); check("drop_low_view", vote_cnt, 0);
    tick(); tick();
    check("drop_no_outputs", {quorum_val, higher_view_val}, 2'b00);

    // Higher view: n=3
    do_reset(4'd3);
    arm_view(32'd4);
    push(1'b0, 32'd9);
    send(2, 32'd9);
    check("higher_val", higher_view_val, 1);
    check("higher_view", higher_view, 9);
    check("higher_rdys", {msg_rdy, arm_rdy, quorum_val}, 3'b000);
    higher_view_rdy = 1'b1;
    tick();
    higher_view_rdy = 1'b0;
    check("higher_to_idle", {higher_view_val, msg_rdy, arm_rdy}, 3'b011);

    // Single node: thresh 0
    cluster_size = 4'd1;
    arm_view(32'd3);
    push(1'b1, 32'd3);
    check("single_first_cycle", quorum_val, 0);
    tick();
    check("single_quorum", {quorum_val, quorum_view}, {1'b1, 32'd3});
    ack_quorum();

    // Re-arm with a same-cycle message
    do_reset(4'd5);
    arm_view(32'd7);
    send(1, 32'd7); check("rearm_pre_cnt", vote_cnt, 1);
    arm = 1'b1; target_view = 32'd8;
    msg_val = 1'b1; msg_replica_idx = 32'd2; msg_view = 32'd8;
    tick();
    arm = 1'b0; msg_val = 1'b0;
    check("rearm_cnt", vote_cnt, 0);
    check("rearm_view", quorum_view, 8);
    push(1'b1, 32'd8);
    send(1, 32'd8); check("rearm_cnt_r1", vote_cnt, 1);
    send(2, 32'd8); check("rearm_cnt_r2", vote_cnt, 2);
    tick();
    check("rearm_quorum", {quorum_val, quorum_view}, {1'b1, 32'd8});
    ack_quorum();

    // Reset mid-collect: n=7 -> thresh 3
    do_reset(4'd7);
    arm_view(32'd5);
    send(1, 32'd5);
    send(2, 32'd5); check("rstmid_pre_cnt", vote_cnt, 2);
    rst_n = 1'b0;
    #1;
    check("rstmid_cnt", vote_cnt, 0);
    check("rstmid_outputs", {quorum_val, higher_view_val, msg_rdy, arm_rdy}, 4'b0011);
    check("rstmid_views", {quorum_view, higher_view}, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    arm_view(32'd5);
    send(1, 32'd5);
    send(2, 32'd5); check("rstmid_cnt2", vote_cnt, 2);
    tick();
    check("rstmid_no_quorum_2", quorum_val, 0);
    push(1'b1, 32'd5);
    send(3, 32'd5); check("rstmid_cnt3", vote_cnt, 3);
    check("rstmid_no_quorum_3", quorum_val, 0);
    tick();
    check("rstmid_quorum", {quorum_val, quorum_view}, {1'b1, 32'd5});
    ack_quorum();

    tick(); tick();
    check("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/start_change_collect.md
# start_change_collect

Receive-side counterpart to the START_CHANGE broadcaster in the VR view-change path. It consumes parsed incoming START_CHANGE messages and tracks which peer replicas have sent one for the view this replica is changing to. It signals quorum once f = (cluster_size-1)/2 distinct other replicas have been heard. It reports any higher view seen so the view-change controller can adopt it.

## Interface
Parameters: none. All widths come from `beehive_vr_pkg`: `CONFIG_NODE_CNT_W`, `CONFIG_ADDR_W`, `INT_W`.

Ports:
- `clk`  in  1  — single clock.
- `rst_n`  in  1  — reset; asynchronous, active-low.
- `cluster_size`  in  CONFIG_NODE_CNT_W  — replica count n; stable while not in IDLE.
- `my_index`  in  INT_W  — own replica index.
- `arm`  in  1  — start collection for `target_view`.
- `target_view`  in  INT_W  — view being collected; sampled on arm handshake.
- `arm_rdy`  out  1  — arm accepted this cycle.
- `msg_val`  in  1  — incoming START_CHANGE message valid.
- `msg_view`  in  INT_W  — view field of the message.
- `msg_replica_idx`  in  INT_W  — sender replica index.
- `msg_rdy`  out  1  — message consumed.
- `quorum_val`  out  1  — quorum reached.
- `quorum_view`  out  INT_W  — view for which quorum was reached.
- `quorum_rdy`  in  1  — consumer acknowledges quorum.
- `higher_view_val`  out  1  — a message with a larger view was seen.
- `higher_view`  out  INT_W  — that larger view.
- `higher_view_rdy`  in  1  — consumer acknowledges the higher view.
- `vote_cnt`  out  CONFIG_NODE_CNT_W  — number of distinct votes counted so far (debug/status).

## Operation
- Threshold: `thresh = (cluster_size-1) >> 1`, computed at CONFIG_NODE_CNT_W width. The value is combinational from `cluster_size`.
- State: a seen-bitmap of width 2**CONFIG_ADDR_W, indexed by replica index; `vote_cnt`; and `view_reg`.
- States:
  - **IDLE**
    - `arm_rdy=1`, `msg_rdy=1`; messages are consumed and dropped.
    - On `arm`: clear the bitmap, `vote_cnt=0`, `view_reg=target_view`, go to COLLECT.
  - **COLLECT**
    - `arm_rdy=1`, `msg_rdy=1`.
    - If `vote_cnt >= thresh`, go to QUORUM. This check happens before message handling, so `thresh=0` reaches quorum the first cycle in COLLECT.
    - For an accepted message, the cases are checked in this order:
      - `msg_replica_idx == my_index`, or `msg_replica_idx >= cluster_size`: drop.
      - `msg_view < view_reg`: drop.
      - `msg_view > view_reg`: latch `higher_view`, go to HIGHER.
      - Bitmap bit already set: drop (duplicate).
      - Otherwise: set the bit, `vote_cnt+1`.
    - `arm` in COLLECT restarts collection exactly as it does in IDLE. It takes priority over a same-cycle message, which is consumed and discarded.
  - **QUORUM**
    - `quorum_val=1`, `quorum_view=view_reg`, `msg_rdy=0`, `arm_rdy=0`.
    - On `quorum_rdy`, go to IDLE.
  - **HIGHER**
    - `higher_view_val=1`, `msg_rdy=0`, `arm_rdy=0`.
    - On `higher_view_rdy`, go to IDLE; the bitmap is abandoned.
- Any illegal state encoding drives outputs to X and `state_next` to X.

## Timing
- Reset values:
  - state = IDLE; bitmap = 0; `vote_cnt = 0`; `view_reg = 0`; `higher_view = 0`.
  - `quorum_val = 0`, `higher_view_val = 0`.
  - `msg_rdy = 1`, `arm_rdy = 1`.
- `msg_rdy` and `arm_rdy` are decoded from the state register only; they have no combinational path from `msg_val` or `arm`.
- Handshakes: valid/ready transfer on the cycle both are high. `quorum_val` and `higher_view_val` hold, with stable data, until their ready is seen.
- Latency:
  - Accepted message to `vote_cnt` update: 1 cycle.
  - Final vote to `quorum_val`: 2 cycles (count register, then state register).
  - Higher-view message to `higher_view_val`: 1 cycle.
- Asserting `rst_n` low mid-collection clears all state immediately; no quorum or higher-view output survives the reset.
- Widths:
  - `vote_cnt` never exceeds `cluster_size-1`.
  - View compares are unsigned at INT_W width; no wrap handling.

## Structure
- The state enum `start_change_collect_state_e` and a `VOTE_MAP_W = 2**CONFIG_ADDR_W` constant go in `beehive_vr_pkg`, alongside the existing message field widths.
- Natural sub-module: `vr_vote_bitmap`. It holds the bitmap plus the distinct-count, with ports for clear, set-index, already-set query and count. The same quorum tracking is reused later for DO_VIEW_CHANGE and PREPARE_OK collection.

## Test plan
- **Basic quorum:** n=5, my_index=0, arm view 7; messages from replica 1, replica 1, replica 2, all view 7.
  - `vote_cnt` goes 1, 1, 2.
  - `quorum_val` asserts 2 cycles after the replica-2 accept, with `quorum_view=7`.
  - With `quorum_rdy` held low for 10 cycles, the output holds stable and `msg_rdy=0` throughout.
- **Drops:** n=5, my_index=0, view 7; messages from replica 0 at view 7, replica 6 at view 7, and replica 3 at view 6.
  - All are consumed; `vote_cnt` stays 0; no output asserts.
- **Higher view:** n=3, view 4; a message from replica 2 at view 9.
  - `higher_view_val` asserts with `higher_view=9`, next cycle.
  - After `higher_view_rdy`, the block returns to IDLE with `arm_rdy=1`.
- **Single node:** n=1, arm view 3.
  - `quorum_val` asserts the cycle after entering COLLECT, with `quorum_view=3`.
- **Re-arm:** n=5, view 7 with one vote counted; `arm` with view 8 in the same cycle as a view-8 message from replica 2.
  - The message is discarded; `vote_cnt=0`; `view_reg=8`.
- **Reset mid-collect:** n=7, two votes counted; pulse `rst_n` low for 1 cycle.
  - All outputs return to their reset values.
  - A following arm plus 3 distinct votes is required before quorum.
